sd_sampler_n: RTL and testbench

Parametrised successor to the LVDA switch-selector data sampler. It captures one of `CHANNELS` parallel `WIDTH`-bit words on request and serialises it MSB-first onto `DATA`, one bit per bit-time strobe. It keeps the set/clear bypass latch `MBYPD`, which redirects the capture to an alternate word source. It sits between the LVDA discrete/telemetry input multiplexing and the LVDC serial data-in path.

---
 rtl/sd_sampler_n.sv | 178 +++++++++++++++++
 tb/tb_sd_sampler_n.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sampler_n.sv
// sd_sampler_n: captures one of CHANNELS words (or the bypass word) and shifts it out MSB-first on BIT_STB.
// Define SD_SAMPLER_PARITY_EN to append an odd-parity bit after the data bits.
module sd_sampler_n #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 14,
  parameter int unsigned CH_W     = $clog2(CHANNELS)
) (
  input  logic                      SIM_CLK,
  input  logic                      SIM_RST,
  input  logic                      BIT_STB,
  input  logic                      START,
  input  logic [CH_W-1:0]           CHAN,
  input  logic [CHANNELS*WIDTH-1:0] DIN,
  input  logic [WIDTH-1:0]          BYP_DIN,
  input  logic                      BYP_SET,
  input  logic                      BYP_CLR,
  output logic                      DATA,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      ERR,
  output logic                      MBYPD
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef SD_SAMPLER_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               mbypd_q, mbypd_d;
  logic [WIDTH-1:0]   sel_word;
  logic [WIDTH-1:0]   cap_word;
  logic               chan_ok;

  // Channel word mux; out-of-range selects yield zero and are flagged via chan_ok.
  always_comb begin
    sel_word = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (CHAN == CH_W'(k)) sel_word = DIN[k*WIDTH +: WIDTH];
    end
  end

  assign chan_ok  = (32'(CHAN) < CHANNELS);
  assign cap_word = mbypd_q ? BYP_DIN : sel_word;

`ifdef SD_SAMPLER_PARITY_EN
  logic par_q, par_d;

  // Parity is taken from the word at capture, since the shifter destroys it.
  always_comb begin
    par_d = par_q;
    if (state_q == ST_IDLE && START && chan_ok) par_d = ~^cap_word;
  end

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) par_q <= 1'b0;
    else          par_q <= par_d;
  end
`endif

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (BYP_CLR)      mbypd_d = 1'b0;
    else if (BYP_SET) mbypd_d = 1'b1;
    else              mbypd_d = mbypd_q;

    case (state_q)
      ST_IDLE: begin
        data_d = 1'b0;
        if (START) begin
          if (chan_ok) begin
            sr_d    = cap_word;
            cnt_d   = '0;
            busy_d  = 1'b1;
            data_d  = cap_word[WIDTH-1];
            state_d = ST_SHIFT;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_SHIFT: begin
        if (BIT_STB) begin
          if (cnt_q == CNT_LAST) begin
`ifdef SD_SAMPLER_PARITY_EN
            state_d = ST_PAR;
            data_d  = par_q;
`else
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            data_d  = 1'b0;
            cnt_d   = '0;
`endif
          end else begin
            sr_d   = {sr_q[WIDTH-2:0], 1'b0};
            cnt_d  = cnt_q + CNT_W'(1);
            data_d = sr_q[WIDTH-2];
          end
        end
      end

`ifdef SD_SAMPLER_PARITY_EN
      ST_PAR: begin
        if (BIT_STB) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          data_d  = 1'b0;
          cnt_d   = '0;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        data_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mbypd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      mbypd_q <= mbypd_d;
    end
  end

  assign DATA  = data_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign ERR   = err_q;
  assign MBYPD = mbypd_q;

endmodule

// File: tb/tb_sd_sampler_n.sv
// Self-checking bench for sd_sampler_n: a 4-channel and a 5-channel instance share clock, reset, strobe and bypass lines.
module tb_sd_sampler_n;

`ifdef SD_SAMPLER_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int NBITS = 14 + PAR_EN;

  logic        clk, rst_n, bit_stb, byp_set, byp_clr;
  logic [13:0] byp_din;
  logic        start4, start5;
  logic [1:0]  chan4;
  logic [2:0]  chan5;
  logic [55:0] din4;
  logic [69:0] din5;
  logic        data4, busy4, done4, err4, mbypd4;
  logic        data5, busy5, done5, err5, mbypd5;

  logic sel5;
  logic o_data, o_busy, o_done, o_err;
  assign o_data = sel5 ? data5 : data4;
  assign o_busy = sel5 ? busy5 : busy4;
  assign o_done = sel5 ? done5 : done4;
  assign o_err  = sel5 ? err5  : err4;

  int n_cmp = 0;
  int n_err = 0;
  bit m_byp = 1'b0;

  sd_sampler_n #(.CHANNELS(4), .WIDTH(14)) u_dut4 (
    .SIM_CLK(clk), .SIM_RST(rst_n), .BIT_STB(bit_stb), .START(start4), .CHAN(chan4),
    .DIN(din4), .BYP_DIN(byp_din), .BYP_SET(byp_set), .BYP_CLR(byp_clr),
    .DATA(data4), .BUSY(busy4), .DONE(done4), .ERR(err4), .MBYPD(mbypd4));

  sd_sampler_n #(.CHANNELS(5), .WIDTH(14)) u_dut5 (
    .SIM_CLK(clk), .SIM_RST(rst_n), .BIT_STB(bit_stb), .START(start5), .CHAN(chan5),
    .DIN(din5), .BYP_DIN(byp_din), .BYP_SET(byp_set), .BYP_CLR(byp_clr),
    .DATA(data5), .BUSY(busy5), .DONE(done5), .ERR(err5), .MBYPD(mbypd5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Serial bit idx of a frame: data bits MSB first, then a bit that makes the total ones count odd.
  function automatic logic exp_bit(input logic [13:0] w, input int idx);
    if (idx < 14) return w[13-idx];
    return (($countones(w) % 2) == 0);
  endfunction

  task automatic bypass(input bit set, input bit clr);
    byp_set = set;
    byp_clr = clr;
    if (clr)      m_byp = 1'b0;
    else if (set) m_byp = 1'b1;
    cycle();
    byp_set = 1'b0;
    byp_clr = 1'b0;
    check("mbypd4", mbypd4, m_byp);
    check("mbypd5", mbypd5, m_byp);
  endtask

  task automatic start_frame(input bit s5, input int ch, input bit with_stb,
                             input bit exp_err, input bit exp_busy, output logic [13:0] w);
    sel5 = s5;
    if (s5) begin start5 = 1'b1; chan5 = 3'(ch); end
    else    begin start4 = 1'b1; chan4 = 2'(ch); end
    bit_stb = with_stb;
    if (exp_err)    w = '0;
    else if (m_byp) w = byp_din;
    else            w = s5 ? din5[ch*14 +: 14] : din4[ch*14 +: 14];
    cycle();
    start4 = 1'b0; start5 = 1'b0; bit_stb = 1'b0;
    check("start_err",  o_err,  exp_err);
    check("start_busy", o_busy, exp_busy);
    check("start_msb",  o_data, exp_busy ? w[13] : 1'b0);
    if (exp_err) begin
      cycle();
      check("err_drop",  o_err,  1'b0);
      check("err_idle",  o_busy, 1'b0);
    end
  endtask

  // Clock out a captured frame with gaps between strobes; optionally disturb inputs mid-frame.
  task automatic run_frame(input logic [13:0] w, input int gmin, input int gmax,
                           input bit disturb, input bit chain);
    for (int i = 0; i < NBITS; i++) begin
      int g = $urandom_range(gmax, gmin);
      for (int c = 0; c < g; c++) begin
        if (disturb) begin
          din4    = 56'({$urandom(), $urandom()});
          din5    = 70'({$urandom(), $urandom(), $urandom()});
          byp_din = 14'($urandom());
          if ($urandom_range(2, 0) == 0) begin
            if (sel5) begin start5 = 1'b1; chan5 = 3'($urandom_range(7, 0)); end
            else      begin start4 = 1'b1; chan4 = 2'($urandom_range(3, 0)); end
          end
          if ($urandom_range(3, 0) == 0) begin
            byp_set = 1'($urandom());
            byp_clr = 1'($urandom());
            if (byp_clr)      m_byp = 1'b0;
            else if (byp_set) m_byp = 1'b1;
          end
        end
        cycle();
        start4 = 1'b0; start5 = 1'b0; byp_set = 1'b0; byp_clr = 1'b0;
        check("hold_data", o_data, exp_bit(w, i));
        check("hold_busy", o_busy, 1'b1);
        check("hold_err",  o_err,  1'b0);
        check("hold_mbyp", mbypd4, m_byp);
      end
      bit_stb = 1'b1;
      cycle();
      bit_stb = 1'b0;
      if (i < NBITS - 1) begin
        check("bit_data", o_data, exp_bit(w, i + 1));
        check("bit_done", o_done, 1'b0);
        check("bit_busy", o_busy, 1'b1);
      end else begin
        check("end_done", o_done, 1'b1);
        check("end_busy", o_busy, 1'b0);
        check("end_data", o_data, 1'b0);
      end
    end
    if (!chain) begin
      cycle();
      check("done_pulse", o_done, 1'b0);
      check("idle_data",  o_data, 1'b0);
    end
  endtask

  typedef struct {
    bit s5;
    int ch;
    bit exp_err;
    bit exp_busy;
  } vec_t;

  initial begin
    vec_t        tbl[7];
    logic [13:0] w;

    tbl[0] = '{0, 2, 0, 1};
    tbl[1] = '{0, 0, 0, 1};
    tbl[2] = '{1, 4, 0, 1};
    tbl[3] = '{1, 5, 1, 0};
    tbl[4] = '{1, 7, 1, 0};
    tbl[5] = '{1, 0, 0, 1};
    tbl[6] = '{0, 3, 0, 1};

    rst_n = 1'b0; bit_stb = 1'b0; byp_set = 1'b0; byp_clr = 1'b0; byp_din = '0;
    start4 = 1'b0; start5 = 1'b0; chan4 = '0; chan5 = '0; din4 = '0; din5 = '0; sel5 = 1'b0;
    cycle();
    cycle();
    check("rst_data",  data4,  1'b0);
    check("rst_busy",  busy4,  1'b0);
    check("rst_done",  done4,  1'b0);
    check("rst_err",   err4,   1'b0);
    check("rst_mbypd", mbypd4, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Basic frame: channel 2 = 14'h2A5A, strobes spaced 3 cycles.
    din4 = '0;
    din4[2*14 +: 14] = 14'h2A5A;
    din4[0 +: 14]    = 14'h0155;
    start_frame(0, 2, 0, 0, 1, w);
    run_frame(14'h2A5A, 2, 2, 0, 0);

    // Bypass latch: clear wins over set; bypass word replaces the channel.
    bypass(1, 0);
    bypass(1, 1);
    bypass(1, 0);
    byp_din = 14'h3FFF;
    start_frame(0, 0, 0, 0, 1, w);
    run_frame(14'h3FFF, 0, 1, 0, 0);
    bypass(0, 1);

    // Table-driven captures on both instances, including out-of-range selects.
    foreach (tbl[i]) begin
      din4 = 56'({$urandom(), $urandom()});
      din5 = 70'({$urandom(), $urandom(), $urandom()});
      start_frame(tbl[i].s5, tbl[i].ch, 0, tbl[i].exp_err, tbl[i].exp_busy, w);
      if (tbl[i].exp_busy) run_frame(w, 0, 2, 0, 0);
    end

    // Back-to-back: START in the DONE cycle, then START together with BIT_STB.
    sel5 = 1'b0;
    din4 = 56'({$urandom(), $urandom()});
    start_frame(0, 1, 0, 0, 1, w);
    run_frame(w, 0, 1, 0, 1);
    din4 = 56'({$urandom(), $urandom()});
    start_frame(0, 3, 0, 0, 1, w);
    run_frame(w, 0, 1, 0, 0);
    start_frame(0, 2, 1, 0, 1, w);
    run_frame(w, 1, 1, 0, 0);

    // Randomised frames with mid-frame disturbances on data, bypass and START.
    for (int it = 0; it < 30; it++) begin
      bit s5;
      int ch;
      bit bad;
      din4    = 56'({$urandom(), $urandom()});
      din5    = 70'({$urandom(), $urandom(), $urandom()});
      byp_din = 14'($urandom());
      if ($urandom_range(2, 0) == 0) bypass(1'($urandom()), 1'($urandom()));
      s5  = 1'($urandom());
      ch  = s5 ? int'($urandom_range(6, 0)) : int'($urandom_range(3, 0));
      bad = s5 ? (ch >= 5) : (ch >= 4);
      start_frame(s5, ch, 1'($urandom()), bad, !bad, w);
      if (!bad) run_frame(w, 0, 3, 1, 0);
    end

    // Reset mid-frame after 5 strobes, with the bypass latch set.
    sel5 = 1'b0;
    bypass(1, 0);
    byp_din = 14'h3FFF;
    start_frame(0, 1, 0, 0, 1, w);
    for (int s = 0; s < 5; s++) begin
      bit_stb = 1'b1;
      cycle();
      bit_stb = 1'b0;
    end
    check("pre_rst_data", data4, 1'b1);
    #2;
    rst_n = 1'b0;
    m_byp = 1'b0;
    #1;
    check("arst_data",  data4,  1'b0);
    check("arst_busy",  busy4,  1'b0);
    check("arst_mbypd", mbypd4, 1'b0);
    check("arst_done",  done4,  1'b0);
    cycle();
    check("rst_hold_done", done4, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      bit_stb = 1'b1;
      cycle();
      bit_stb = 1'b0;
      check("idle_stb_data", data4, 1'b0);
      check("idle_stb_busy", busy4, 1'b0);
      check("idle_stb_done", done4, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
